// File: rtl/burst_mem_responder.sv
// Line-granular burst memory responder: fixed-latency cacheline reads/writes as BEATS beats.
// Optional perf counters are built when BURST_MEM_PERF_EN is defined.
module burst_mem_responder #(
  parameter int DATA_W     = 64,
  parameter int BEATS      = 4,
  parameter int LINE_IDX_W = 8,
  parameter int LATENCY    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [31:0]       address_i,
  input  logic [DATA_W-1:0] burst_i,
  output logic [DATA_W-1:0] burst_o,
  output logic              resp_o,
  output logic              err_o
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_e;

  state_e                state_q, state_d;
  logic [7:0]            lat_q, lat_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [LINE_IDX_W-1:0] idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  req_held;
  logic                  mem_we;
  logic                  unused_addr;

  logic [DATA_W-1:0] mem_q [0:(1<<LINE_IDX_W)-1][0:BEATS-1];

  assign unused_addr = ^{address_i[4:0], address_i[31:5+LINE_IDX_W]};
  // The request that must stay high is the one matching the latched direction.
  assign req_held = wr_q ? write_i : read_i;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    err_d   = err_q;
    rdata_d = '0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_i | write_i) begin
          state_d = WAIT;
          idx_d   = address_i[5+LINE_IDX_W-1:5];
          wr_d    = write_i & ~read_i;
          lat_d   = LAT_M1;
          beat_d  = '0;
          if (read_i & write_i) err_d = 1'b1;
        end
      end
      WAIT: begin
        if (!req_held) begin
          state_d = IDLE;
          err_d   = 1'b1;
          lat_d   = '0;
        end else if (lat_q == '0) begin
          state_d = BURST;
          beat_d  = '0;
          if (!wr_q) rdata_d = mem_q[idx_q][0];
        end else begin
          lat_d = lat_q - 8'd1;
        end
      end
      BURST: begin
        if (!req_held) begin
          state_d = IDLE;
          err_d   = 1'b1;
          beat_d  = '0;
        end else begin
          mem_we = wr_q;
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
            if (!wr_q) rdata_d = mem_q[idx_q][beat_q + 1'b1];
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately outside reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q][beat_q] <= burst_i;
  end

  assign burst_o = rdata_q;
  assign resp_o  = (state_q == BURST);
  assign err_o   = err_q;

`ifdef BURST_MEM_PERF_EN
  logic [31:0] rd_line_count;
  logic [31:0] wr_line_count;
  logic [31:0] busy_cycle_count;
  logic        last_beat;

  assign last_beat = (state_q == BURST) && req_held && (beat_q == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_line_count    <= '0;
      wr_line_count    <= '0;
      busy_cycle_count <= '0;
    end else begin
      if (last_beat && !wr_q && rd_line_count != '1) rd_line_count <= rd_line_count + 32'd1;
      if (last_beat && wr_q && wr_line_count != '1) wr_line_count <= wr_line_count + 32'd1;
      if (state_q != IDLE && busy_cycle_count != '1) busy_cycle_count <= busy_cycle_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_burst_mem_responder.sv
// Table-driven bench with a read-beat scoreboard for burst_mem_responder (LATENCY=8).
module tb_burst_mem_responder;

  localparam int DW    = 64;
  localparam int BEATS = 4;
  localparam int LAT   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          read_i = 1'b0;
  logic          write_i = 1'b0;
  logic [31:0]   address_i = '0;
  logic [DW-1:0] burst_i = '0;
  logic [DW-1:0] burst_o;
  logic          resp_o;
  logic          err_o;

  burst_mem_responder #(.DATA_W(DW), .BEATS(BEATS), .LINE_IDX_W(8), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .burst_i(burst_i), .burst_o(burst_o),
    .resp_o(resp_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef logic [BEATS-1:0][DW-1:0] line_t;
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    line_t       d;
  } vec_t;

  int          nvec = 0;
  int          nfail = 0;
  bit          exp_err = 1'b0;
  logic [DW-1:0] sb_q[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic line_t mkline(input logic [DW-1:0] b0, b1, b2, b3);
    line_t l;
    l[0] = b0; l[1] = b1; l[2] = b2; l[3] = b3;
    return l;
  endfunction

  function automatic vec_t mkvec(input bit wr, input logic [31:0] addr, input line_t d);
    vec_t v;
    v.wr = wr; v.addr = addr; v.d = d;
    return v;
  endfunction

  // Caller sits just after a rising edge; returns just after a rising edge.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr, input line_t d,
                         input int drop, input bit hold, input string tag);
    int   last_c, resp_end, nbeats;
    logic exp_resp;
    logic [DW-1:0] e;
    last_c   = hold ? 2*(LAT+BEATS)+2 : LAT+BEATS+1;
    resp_end = (drop >= 0) ? LAT+drop : LAT+BEATS-1;
    nbeats   = (drop >= 0) ? drop+1 : BEATS;
    #1;
    read_i = rd; write_i = wr; address_i = addr;
    if (rd) for (int k = 0; k < nbeats; k++) sb_q.push_back(d[k]);
    @(posedge clk);
    for (int c = 0; c <= last_c; c++) begin
      #1;
      if (wr && !rd && c >= LAT && c < LAT+BEATS) burst_i = d[c-LAT];
      else burst_i = {$urandom, $urandom};
      if (drop >= 0 && c == LAT+drop) begin read_i = 1'b0; write_i = 1'b0; end
      if (c == (hold ? LAT+BEATS+1 : LAT+BEATS)) begin read_i = 1'b0; write_i = 1'b0; end
      @(negedge clk);
      exp_resp = (c >= LAT && c <= resp_end);
      chk($sformatf("%s resp c%0d", tag, c), {63'b0, resp_o}, {63'b0, exp_resp});
      if (resp_o && rd) begin
        if (sb_q.size() == 0) begin
          chk($sformatf("%s unexpected beat c%0d", tag, c), burst_o, 'x);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("%s beat c%0d", tag, c), burst_o, e);
        end
      end else begin
        chk($sformatf("%s burst_o zero c%0d", tag, c), burst_o, '0);
      end
      @(posedge clk);
    end
    chk({tag, " beats outstanding"}, DW'(sb_q.size()), '0);
    sb_q.delete();
    chk({tag, " err"}, {63'b0, err_o}, {63'b0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[9];
    line_t l40, l100, l20, l80, l60, l80n, l80mix;
    l40  = mkline({8{8'h11}}, {8{8'h22}}, {8{8'h33}}, {8{8'h44}});
    l100 = mkline({8{8'hA1}}, {8{8'hA2}}, {8{8'hA3}}, {8{8'hA4}});
    l20  = mkline({8{8'hC1}}, {8{8'hC2}}, {8{8'hC3}}, {8{8'hC4}});
    l80  = mkline({8{8'hE1}}, {8{8'hE2}}, {8{8'hE3}}, {8{8'hE4}});
    l60  = mkline(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0, 64'hFFFFFFFFFFFFFFFF);
    l80n = mkline({8{8'h5A}}, {8{8'h6B}}, {8{8'h7C}}, {8{8'h8D}});
    l80mix = mkline(l80n[0], l80n[1], l80[2], l80[3]);
    tbl[0] = mkvec(1'b1, 32'h0000_0040, l40);
    tbl[1] = mkvec(1'b0, 32'h0000_0040, l40);
    tbl[2] = mkvec(1'b1, 32'h0000_0100, l100);
    tbl[3] = mkvec(1'b1, 32'h0000_0020, l20);
    tbl[4] = mkvec(1'b1, 32'h0000_0080, l80);
    tbl[5] = mkvec(1'b1, 32'h0000_0060, l60);
    tbl[6] = mkvec(1'b0, 32'h0000_2060, l60);
    tbl[7] = mkvec(1'b0, 32'hFFFF_E07F, l60);
    tbl[8] = mkvec(1'b0, 32'h0000_0100, l100);

    #1 rst_n = 1'b0;
    #1;
    chk("reset resp_o", {63'b0, resp_o}, '0);
    chk("reset burst_o", burst_o, '0);
    chk("reset err_o", {63'b0, err_o}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 9; i++)
      run_txn(!tbl[i].wr, tbl[i].wr, tbl[i].addr, tbl[i].d, -1, 1'b0, $sformatf("vec%0d", i));

    run_txn(1'b1, 1'b0, 32'h0000_0100, l100, -1, 1'b1, "hold");

    exp_err = 1'b1;
    run_txn(1'b1, 1'b1, 32'h0000_0020, l20, -1, 1'b0, "both");
    run_txn(1'b1, 1'b0, 32'h0000_0020, l20, -1, 1'b0, "both_reread");

    run_txn(1'b0, 1'b1, 32'h0000_0080, l80n, 2, 1'b0, "wdrop");
    run_txn(1'b1, 1'b0, 32'h0000_0080, l80mix, -1, 1'b0, "wdrop_read");

    #1;
    read_i = 1'b1; address_i = 32'h0000_0040;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    read_i = 1'b0;
    #1;
    chk("rst_wait resp_o", {63'b0, resp_o}, '0);
    chk("rst_wait burst_o", burst_o, '0);
    chk("rst_wait err_o", {63'b0, err_o}, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_err = 1'b0;
    @(posedge clk);
    run_txn(1'b1, 1'b0, 32'h0000_0040, l40, -1, 1'b0, "post_reset");

`ifdef BURST_MEM_PERF_EN
    #1;
    chk("perf rd_line_count", DW'(dut.rd_line_count), DW'(1));
    chk("perf wr_line_count", DW'(dut.wr_line_count), DW'(0));
    chk("perf busy_cycle_count", DW'(dut.busy_cycle_count), DW'(LAT+BEATS+1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
